// File: rtl/cpuc_package.sv
// Shared CPUC definitions: datapath width, compare signedness, the min/max
// reduction FSM state encoding and the result record it produces.
package cpuc_package;

  localparam int DATA_WIDTH = 8;
  localparam bit SIGNED_CMP = 1'b1;

  // Widest beat counter any min/max reducer instance may use.
  localparam int MINMAX_CNT_MAX_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } t_minmax_state;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]       max;
    logic [DATA_WIDTH-1:0]       min;
    logic [MINMAX_CNT_MAX_W-1:0] count;
    logic                        trunc;
  } t_minmax_res;

endpackage

// File: rtl/cpuc_minmax_unit.sv
// Combinational max/min compare unit. Ties keep the stored value, so the
// first occurrence of an extreme wins. Signedness follows SIGNED_CMP.
module cpuc_minmax_unit
  import cpuc_package::*;
(
  input  logic [DATA_WIDTH-1:0] cur_max,
  input  logic [DATA_WIDTH-1:0] cur_min,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] nxt_max,
  output logic [DATA_WIDTH-1:0] nxt_min,
  output logic                  max_upd,
  output logic                  min_upd
);

  // Strict comparisons only: equal values never replace the stored extreme.
  always_comb begin
    max_upd = 1'b0;
    min_upd = 1'b0;
    if (SIGNED_CMP) begin
      max_upd = $signed(data) > $signed(cur_max);
      min_upd = $signed(data) < $signed(cur_min);
    end else begin
      max_upd = data > cur_max;
      min_upd = data < cur_min;
    end
    nxt_max = max_upd ? data : cur_max;
    nxt_min = min_upd ? data : cur_min;
  end

endmodule

// File: rtl/cpuc_minmax_reduce.sv
// Streaming min/max reducer for the CPUC compare path. Folds a valid/ready
// frame into a single result beat carrying max, min, beat count and a
// truncation flag. Beats past MAX_FRAME_LEN are dropped until in_last.
// Optional feature: define CPUC_MINMAX_INDEX_EN to add out_max_idx and
// out_min_idx, the 0-based beat index of the first max/min occurrence.
module cpuc_minmax_reduce
  import cpuc_package::*;
#(
  parameter int MAX_FRAME_LEN = 256,
  parameter int CNT_W         = $clog2(MAX_FRAME_LEN + 1),
  localparam int IDX_W        = (CNT_W > 1) ? (CNT_W - 1) : 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic [DATA_WIDTH-1:0] out_min,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_trunc
`ifdef CPUC_MINMAX_INDEX_EN
  ,
  output logic [IDX_W-1:0]      out_max_idx,
  output logic [IDX_W-1:0]      out_min_idx
`endif
);

  localparam logic [MINMAX_CNT_MAX_W-1:0] MAX_LEN_C = MINMAX_CNT_MAX_W'(MAX_FRAME_LEN);

  t_minmax_state state;
  t_minmax_state state_nxt;
  t_minmax_res   res;

  logic                        acc_ready;
  logic                        in_fire;
  logic                        out_fire;
  logic [MINMAX_CNT_MAX_W-1:0] next_count;
  logic                        first_at_limit;
  logic                        accum_at_limit;

  logic [DATA_WIDTH-1:0] cmp_max;
  logic [DATA_WIDTH-1:0] cmp_min;
  logic                  max_upd;
  logic                  min_upd;

  // Input is blocked only while a result is waiting, and while in reset.
  assign acc_ready      = (state != S_DONE) && !Rst;
  assign in_ready       = acc_ready;
  assign in_fire        = in_valid && acc_ready;
  assign out_valid      = (state == S_DONE);
  assign out_fire       = out_valid && out_ready;
  assign next_count     = res.count + MINMAX_CNT_MAX_W'(1);
  assign first_at_limit = (MAX_LEN_C == MINMAX_CNT_MAX_W'(1));
  assign accum_at_limit = (next_count == MAX_LEN_C);

  assign out_max   = res.max;
  assign out_min   = res.min;
  assign out_count = res.count[CNT_W-1:0];
  assign out_trunc = res.trunc;

  cpuc_minmax_unit u_unit (
    .cur_max (res.max),
    .cur_min (res.min),
    .data    (in_data),
    .nxt_max (cmp_max),
    .nxt_min (cmp_min),
    .max_upd (max_upd),
    .min_upd (min_upd)
  );

  // State register; reset mid-frame abandons the partial frame.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: frame end or length limit closes the frame, a
  // truncated frame drains its remaining beats after the result is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_fire && (in_last || first_at_limit)) begin
          state_nxt = S_DONE;
        end else if (in_fire) begin
          state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_fire && (in_last || accum_at_limit)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_fire) begin
          state_nxt = res.trunc ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (in_fire && in_last) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result accumulation: first beat seeds the record, later beats fold in.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      res <= '0;
    end else if (in_fire && (state == S_IDLE)) begin
      res.max   <= in_data;
      res.min   <= in_data;
      res.count <= MINMAX_CNT_MAX_W'(1);
      res.trunc <= first_at_limit && !in_last;
    end else if (in_fire && (state == S_ACCUM)) begin
      res.max   <= cmp_max;
      res.min   <= cmp_min;
      res.count <= next_count;
      res.trunc <= accum_at_limit && !in_last;
    end
  end

`ifdef CPUC_MINMAX_INDEX_EN
  logic [IDX_W-1:0] max_idx;
  logic [IDX_W-1:0] min_idx;

  assign out_max_idx = max_idx;
  assign out_min_idx = min_idx;

  // Index capture: the current beat's index is the count before increment.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      max_idx <= '0;
      min_idx <= '0;
    end else if (in_fire && (state == S_IDLE)) begin
      max_idx <= '0;
      min_idx <= '0;
    end else if (in_fire && (state == S_ACCUM)) begin
      if (max_upd) begin
        max_idx <= res.count[IDX_W-1:0];
      end
      if (min_upd) begin
        min_idx <= res.count[IDX_W-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpuc_minmax_reduce.sv
// Directed testbench for cpuc_minmax_reduce. Uses a default-length instance
// and a MAX_FRAME_LEN=4 instance for truncation. Honours
// CPUC_MINMAX_INDEX_EN when the design is built with it.
module tb_cpuc_minmax_reduce;
  import cpuc_package::*;

  localparam logic [7:0] SGN_MAX = SIGNED_CMP ? 8'h7F : 8'h80;
  localparam logic [7:0] SGN_MIN = SIGNED_CMP ? 8'h80 : 8'h00;

  logic Clk;
  logic Rst;

  logic                  in_valid, in_ready, in_last, out_valid, out_ready, out_trunc;
  logic [DATA_WIDTH-1:0] in_data, out_max, out_min;
  logic [8:0]            out_count;

  logic                  v4, r4, l4, ov4, or4, tr4;
  logic [DATA_WIDTH-1:0] d4, max4, min4;
  logic [2:0]            cnt4;

`ifdef CPUC_MINMAX_INDEX_EN
  logic [7:0] max_idx, min_idx;
  logic [1:0] max_idx4, min_idx4;
`endif

  int checks = 0;
  int errors = 0;

  cpuc_minmax_reduce dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_count (out_count),
    .out_trunc (out_trunc)
`ifdef CPUC_MINMAX_INDEX_EN
    ,
    .out_max_idx (max_idx),
    .out_min_idx (min_idx)
`endif
  );

  cpuc_minmax_reduce #(.MAX_FRAME_LEN(4)) dut4 (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (v4),
    .in_ready  (r4),
    .in_data   (d4),
    .in_last   (l4),
    .out_valid (ov4),
    .out_ready (or4),
    .out_max   (max4),
    .out_min   (min4),
    .out_count (cnt4),
    .out_trunc (tr4)
`ifdef CPUC_MINMAX_INDEX_EN
    ,
    .out_max_idx (max_idx4),
    .out_min_idx (min_idx4)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 30) begin
      @(posedge Clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL send_ready: got %b expected 1 (data %0h)", in_ready, d);
    end
    @(posedge Clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_beat4(input logic [7:0] d, input logic l);
    int n = 0;
    v4 = 1'b1;
    d4 = d;
    l4 = l;
    while (!r4 && n < 30) begin
      @(posedge Clk); #1;
      n++;
    end
    checks++;
    if (r4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL send4_ready: got %b expected 1 (data %0h)", r4, d);
    end
    @(posedge Clk); #1;
    v4 = 1'b0;
    l4 = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || r4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready_valid: got ready %b valid %b ready4 %b expected 0 0 0", in_ready, out_valid, r4);
    end
    checks++;
    if (out_max !== 8'h00 || out_min !== 8'h00 || out_count !== 9'd0 || out_trunc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %0h %0h %0d %b expected 0 0 0 0", out_max, out_min, out_count, out_trunc);
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_unsigned_frame();
    out_ready = 1'b1;
    send_beat(8'd5, 1'b0);
    send_beat(8'd3, 1'b0);
    send_beat(8'd9, 1'b0);
    send_beat(8'd9, 1'b0);
    send_beat(8'd1, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_latency: got out_valid %b expected 1", out_valid);
    end
    checks++;
    if (out_max !== 8'd9 || out_min !== 8'd1) begin
      errors++;
      $display("[TB] FAIL basic_maxmin: got %0d/%0d expected 9/1", out_max, out_min);
    end
    checks++;
    if (out_count !== 9'd5 || out_trunc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_count_trunc: got %0d/%b expected 5/0", out_count, out_trunc);
    end
`ifdef CPUC_MINMAX_INDEX_EN
    checks++;
    if (max_idx !== 8'd2 || min_idx !== 8'd4) begin
      errors++;
      $display("[TB] FAIL basic_idx: got %0d/%0d expected 2/4", max_idx, min_idx);
    end
`endif
    @(posedge Clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_handshake: got valid %b ready %b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_signed_frame();
    out_ready = 1'b1;
    send_beat(8'h7F, 1'b0);
    send_beat(8'h80, 1'b0);
    send_beat(8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_max !== SGN_MAX || out_min !== SGN_MIN) begin
      errors++;
      $display("[TB] FAIL signed_maxmin: got v%b %0h/%0h expected v1 %0h/%0h", out_valid, out_max, out_min, SGN_MAX, SGN_MIN);
    end
    checks++;
    if (out_count !== 9'd3) begin
      errors++;
      $display("[TB] FAIL signed_count: got %0d expected 3", out_count);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_single_beat();
    out_ready = 1'b0;
    send_beat(8'h42, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_max !== 8'h42 || out_min !== 8'h42 || out_count !== 9'd1) begin
      errors++;
      $display("[TB] FAIL single_result: got v%b %0h/%0h c%0d expected v1 42/42 c1", out_valid, out_max, out_min, out_count);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_in_ready: got %b expected 0", in_ready);
    end
    out_ready = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    out_ready = 1'b0;
    send_beat(8'h10, 1'b0);
    send_beat(8'h30, 1'b0);
    send_beat(8'h20, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== 8'h30 ||
          out_min !== 8'h10 || out_count !== 9'd3) begin
        errors++;
        bad++;
        $display("[TB] FAIL hold_cycle%0d: got v%b r%b %0h/%0h c%0d expected v1 r0 30/10 c3",
                 i, out_valid, in_ready, out_max, out_min, out_count);
      end
      @(posedge Clk); #1;
    end
    out_ready = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_release: got valid %b ready %b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_beat(8'h08, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== 8'h08) begin
      errors++;
      $display("[TB] FAIL b2b_first: got v%b r%b max %0h expected v1 r0 max 08", out_valid, in_ready, out_max);
    end
    send_beat(8'h03, 1'b0);
    send_beat(8'h0C, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_max !== 8'h0C || out_min !== 8'h03 || out_count !== 9'd2) begin
      errors++;
      $display("[TB] FAIL b2b_second: got v%b %0h/%0h c%0d expected v1 0c/03 c2", out_valid, out_max, out_min, out_count);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_truncation();
    or4 = 1'b0;
    send_beat4(8'd1, 1'b0);
    send_beat4(8'd2, 1'b0);
    send_beat4(8'd3, 1'b0);
    send_beat4(8'd4, 1'b0);
    checks++;
    if (ov4 !== 1'b1 || r4 !== 1'b0 || max4 !== 8'd4 || min4 !== 8'd1) begin
      errors++;
      $display("[TB] FAIL trunc_result: got v%b r%b %0d/%0d expected v1 r0 4/1", ov4, r4, max4, min4);
    end
    checks++;
    if (cnt4 !== 3'd4 || tr4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL trunc_count_flag: got %0d/%b expected 4/1", cnt4, tr4);
    end
`ifdef CPUC_MINMAX_INDEX_EN
    checks++;
    if (max_idx4 !== 2'd3 || min_idx4 !== 2'd0) begin
      errors++;
      $display("[TB] FAIL trunc_idx: got %0d/%0d expected 3/0", max_idx4, min_idx4);
    end
`endif
    or4 = 1'b1;
    send_beat4(8'd5, 1'b0);
    send_beat4(8'd6, 1'b1);
    checks++;
    if (ov4 !== 1'b0 || cnt4 !== 3'd4 || max4 !== 8'd4) begin
      errors++;
      $display("[TB] FAIL trunc_drain: got v%b c%0d max %0d expected v0 c4 max 4", ov4, cnt4, max4);
    end
    send_beat4(8'd7, 1'b1);
    checks++;
    if (ov4 !== 1'b1 || max4 !== 8'd7 || min4 !== 8'd7 || cnt4 !== 3'd1 || tr4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL trunc_next_frame: got v%b %0d/%0d c%0d t%b expected v1 7/7 c1 t0", ov4, max4, min4, cnt4, tr4);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_midframe_reset();
    out_ready = 1'b1;
    send_beat(8'h50, 1'b0);
    send_beat(8'h60, 1'b0);
    Rst = 1'b1;
    #1;
    checks++;
    if (out_max !== 8'h00 || out_min !== 8'h00 || out_count !== 9'd0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_async: got %0h/%0h c%0d r%b v%b expected 0/0 c0 r0 v0", out_max, out_min, out_count, in_ready, out_valid);
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_no_result%0d: got out_valid %b expected 0", i, out_valid);
      end
    end
    send_beat(8'h11, 1'b0);
    send_beat(8'h05, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_max !== 8'h11 || out_min !== 8'h05 || out_count !== 9'd2) begin
      errors++;
      $display("[TB] FAIL rst_next_frame: got v%b %0h/%0h c%0d expected v1 11/05 c2", out_valid, out_max, out_min, out_count);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    v4        = 1'b0;
    d4        = '0;
    l4        = 1'b0;
    or4       = 1'b0;
    test_reset();
    test_unsigned_frame();
    test_signed_frame();
    test_single_beat();
    test_backpressure();
    test_back_to_back();
    test_truncation();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
